// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and
// the legal range of the operand width.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/adder_fl1bit.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module adder_fl1bit (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic out,
  output logic cout
);

  assign out  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (in1 & cin) | (in2 & cin);

endmodule

// File: rtl/adder_serial.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB
// first, WIDTH cycles per operation, with a start/busy/done handshake.
module adder_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("adder_serial: WIDTH out of range");
  end

  // Handshake: start is a level sampled only in IDLE/DONE; busy marks RUN;
  // done is a one-cycle pulse in DONE, the cycle the new result is first visible.
  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;
  logic               accept;

  adder_fl1bit u_fa (
    .in1  (a_q[0]),
    .in2  (b_q[0]),
    .cin  (carry_q),
    .out  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_LAST);
  assign accept   = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is in1 + ~in2 + 1: B is inverted at load and the carry seeded with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= in1;
      b_q     <= sub ? ~in2 : in2;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (last_bit) begin
        // carry_q here is the carry into the MSB, so ovf needs no extra register.
        out  <= {fa_sum, sum_q[WIDTH-1:1]};
        cout <= fa_cout;
        ovf  <= carry_q ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
// Directed bench for adder_serial at WIDTH=8: arithmetic, handshake timing,
// start-during-run, back-to-back operation and reset behaviour.
module tb_adder_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         cout;
  logic         ovf;

  int total = 0;
  int passed = 0;
  int overlap = 0;

  adder_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (busy && done) overlap++;

  // Driver tasks. All return #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for exactly one sampling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    tick();
    start = 1'b1;
    in1 = a;
    in2 = b;
    sub = s;
    tick();
    start = 1'b0;
  endtask

  // Called in the first cycle after the start edge; lat counts cycles until done.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (out !== 8'd0) $display("FAIL reset_out: got %0d expected 0", out); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else passed++;
  endtask

  task automatic test_add();
    int lat, bc;
    start_op(8'd100, 8'd27, 1'b0);
    wait_done(lat, bc);
    total++; if (lat !== 8) $display("FAIL add_latency: got %0d expected 8", lat); else passed++;
    total++; if (bc !== 8) $display("FAIL add_busy_cycles: got %0d expected 8", bc); else passed++;
    total++; if (out !== 8'd127) $display("FAIL add_100_27_out: got %0d expected 127", out); else passed++;
    total++; if ({cout, ovf} !== 2'b00) $display("FAIL add_100_27_flags: got cout=%b ovf=%b expected 0 0", cout, ovf); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else passed++;
    total++; if (out !== 8'd127) $display("FAIL out_held: got %0d expected 127", out); else passed++;

    start_op(8'd255, 8'd1, 1'b0);
    wait_done(lat, bc);
    total++; if (out !== 8'd0) $display("FAIL add_255_1_out: got %0d expected 0", out); else passed++;
    total++; if ({cout, ovf} !== 2'b10) $display("FAIL add_255_1_flags: got cout=%b ovf=%b expected 1 0", cout, ovf); else passed++;

    start_op(8'd127, 8'd1, 1'b0);
    wait_done(lat, bc);
    total++; if (out !== 8'd128) $display("FAIL add_127_1_out: got %0d expected 128", out); else passed++;
    total++; if ({cout, ovf} !== 2'b01) $display("FAIL add_127_1_flags: got cout=%b ovf=%b expected 0 1", cout, ovf); else passed++;
  endtask

  task automatic test_sub();
    int lat, bc;
    start_op(8'd5, 8'd7, 1'b1);
    wait_done(lat, bc);
    total++; if (out !== 8'hFE) $display("FAIL sub_5_7_out: got %h expected fe", out); else passed++;
    total++; if ({cout, ovf} !== 2'b00) $display("FAIL sub_5_7_flags: got cout=%b ovf=%b expected 0 0", cout, ovf); else passed++;

    start_op(8'd7, 8'd5, 1'b1);
    wait_done(lat, bc);
    total++; if (out !== 8'd2) $display("FAIL sub_7_5_out: got %0d expected 2", out); else passed++;
    total++; if ({cout, ovf} !== 2'b10) $display("FAIL sub_7_5_flags: got cout=%b ovf=%b expected 1 0", cout, ovf); else passed++;

    start_op(8'h80, 8'd1, 1'b1);
    wait_done(lat, bc);
    total++; if (out !== 8'h7F) $display("FAIL sub_80_1_out: got %h expected 7f", out); else passed++;
    total++; if ({cout, ovf} !== 2'b11) $display("FAIL sub_80_1_flags: got cout=%b ovf=%b expected 1 1", cout, ovf); else passed++;
  endtask

  task automatic test_start_ignored();
    int dones, first_lat;
    logic [W-1:0] first_out;
    start_op(8'd3, 8'd4, 1'b0);
    tick();
    tick();
    start = 1'b1;
    in1 = 8'd50;
    in2 = 8'd50;
    tick();
    start = 1'b0;
    dones = 0;
    first_lat = -1;
    first_out = '0;
    for (int i = 3; i < 24; i++) begin
      if (done) begin
        dones++;
        if (first_lat < 0) begin
          first_lat = i;
          first_out = out;
        end
      end
      tick();
    end
    total++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d expected 1", dones); else passed++;
    total++; if (first_lat !== 8) $display("FAIL ignore_latency: got %0d expected 8", first_lat); else passed++;
    total++; if (first_out !== 8'd7) $display("FAIL ignore_out: got %0d expected 7", first_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(8'd1, 8'd2, 1'b0);
    wait_done(lat, bc);
    total++; if (out !== 8'd3) $display("FAIL b2b_first_out: got %0d expected 3", out); else passed++;
    start = 1'b1;
    in1 = 8'd10;
    in2 = 8'd20;
    sub = 1'b0;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy_after_done: got %b expected 1", busy); else passed++;
    wait_done(lat, bc);
    total++; if (lat + 1 !== 9) $display("FAIL b2b_gap: got %0d expected 9", lat + 1); else passed++;
    total++; if (out !== 8'd30) $display("FAIL b2b_second_out: got %0d expected 30", out); else passed++;
  endtask

  task automatic test_rst_mid_run();
    int lat, bc, dones;
    start_op(8'd200, 8'd100, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({busy, done} !== 2'b00) $display("FAIL rst_run_hs: got busy=%b done=%b expected 0 0", busy, done); else passed++;
    total++; if (out !== 8'd0) $display("FAIL rst_run_out: got %0d expected 0", out); else passed++;
    total++; if ({cout, ovf} !== 2'b00) $display("FAIL rst_run_flags: got cout=%b ovf=%b expected 0 0", cout, ovf); else passed++;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    total++; if (dones !== 0) $display("FAIL rst_run_no_done: got %0d expected 0", dones); else passed++;

    rst = 1'b1;
    start = 1'b1;
    in1 = 8'd9;
    in2 = 8'd9;
    tick();
    rst = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rst_with_start_busy: got %b expected 0", busy); else passed++;

    start_op(8'd1, 8'd1, 1'b0);
    wait_done(lat, bc);
    total++; if (out !== 8'd2) $display("FAIL rst_then_1_1_out: got %0d expected 2", out); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_rst_mid_run();
    total++; if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
# adder_serial

Parametrised bit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single 1-bit full-adder cell. It is the sequential successor to the 1-bit adder cells and serves as the area-minimal arithmetic unit for datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake controls it, and it holds the result until the next operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE state.
- sub  in  1  mode, sampled with start: 0 = in1+in2, 1 = in1-in2.
- in1  in  WIDTH  operand A, sampled with start.
- in2  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse when the result is updated.
- out  out  WIDTH  result (mod 2^WIDTH); held between operations.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch in1 into shift register A;
  - latch in2 (or ~in2 if sub=1) into shift register B;
  - carry register := sub; bit counter := 0; go to RUN.
- IDLE, start=0: stay.
- RUN, each cycle:
  - the full-adder cell sums A[0], B[0] and carry;
  - the sum bit shifts into the MSB of the internal sum register;
  - A and B shift right; carry := cell carry-out;
  - when the counter = WIDTH-1, the MSB carry-in is captured for ovf;
  - counter increments.
- RUN, on the cycle the counter = WIDTH-1:
  - update out, cout and ovf from the final sum/carry values;
  - go to DONE.
- DONE:
  - done=1 for exactly one cycle;
  - start=1 here is accepted exactly as in IDLE and goes straight to RUN;
  - otherwise go to IDLE.
- start during RUN is ignored; its operands and sub are not captured.
- out, cout and ovf change only on completion; partial sums are never visible.
- Arithmetic: subtraction is in1 + ~in2 + 1, so cout=1 means in1 >= in2 (unsigned).

## Timing
- Reset values: busy=0, done=0, out=0, cout=0, ovf=0; FSM=IDLE; counter, carry and shift registers = 0.
- Latency: with start sampled at edge t, busy=1 from t+1 until t+WIDTH.
- done=1 and the new out/cout/ovf are valid in the cycle after edge t+WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: with back-to-back start in the DONE cycle, one result every WIDTH+1 cycles.
- busy and done are never high together.
- rst mid-RUN:
  - all state returns to reset values at the same edge;
  - no done pulse is produced;
  - the previous result is cleared to 0.
- rst together with start: rst wins and the operation is not accepted.
- Counter width: $clog2(WIDTH); WIDTH-1 must be representable.

## Structure
- Shared package adder_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - WIDTH legality bounds (WIDTH_MIN=2, WIDTH_MAX=64).
- One sub-module: adder_fl1bit, a combinational 1-bit full adder (in1, in2, cin -> out, cout), instantiated once.
- The remainder is a single module: FSM, counter, operand shifters, sum register, result registers.

## Test plan
All scenarios use WIDTH=8.
- 100+27 (sub=0) -> out=127, cout=0, ovf=0, done exactly 8 cycles after the start edge, busy high for 8 cycles.
- 255+1 -> out=0, cout=1, ovf=0; 127+1 -> out=128, cout=0, ovf=1.
- sub=1:
  - 5-7 -> out=8'hFE, cout=0, ovf=0;
  - 7-5 -> out=2, cout=1, ovf=0;
  - 8'h80-1 -> out=8'h7F, ovf=1.
- start with 3+4 held, then start pulsed again with 50+50 during RUN (cycle 3) -> single done, out=7.
- Back-to-back: start=1 again during the DONE cycle with 10+20 -> second done exactly 9 cycles after the first; out=30.
- rst asserted at RUN cycle 4 of 200+100 -> next cycle busy=0, done=0, out=0, cout=0, ovf=0; no done for 10 cycles; a following 1+1 yields out=2.
